mem_port_arbiter: RTL and testbench

- Shares the single main-memory block port (10-bit address, 128-bit block data, read_write with 1=write) between two cache requesters, e.g. I-cache and D-cache.
- Sequences each transfer over a fixed MEM_LATENCY-cycle access window.
- Returns read blocks with a one-cycle ack pulse.
- Round-robin arbitration; sits between the caches' miss/write-through ports and mainmem.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the main-memory block port and its arbiter.
package mem_pkg;

   localparam int ADDR_W  = 10;
   localparam int BLOCK_W = 128;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      DONE   = 2'b10
   } arb_state_t;

   // Round-robin pick between two requesters; a lone request always wins,
   // a tie goes to whoever was not granted last.
   function automatic logic pickWinner(input logic r0, input logic r1, input logic lastGrant);
      logic w;
      if (r0 && r1) begin
         w = ~lastGrant;
      end else begin
         w = r1;
      end
      return w;
   endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of the main-memory block port.
// Each transfer holds the port for a fixed MEM_LATENCY-cycle window, then
// pulses the winner's ack for one cycle (read data is valid with the ack).
//
//   state  | meaning
//   IDLE   | port free; requests sampled at every edge
//   ACCESS | latched transfer driven on mem_* for MEM_LATENCY cycles
//   DONE   | winner's ack high for this cycle; requests not sampled
module mem_port_arbiter #(
   parameter int ADDR_W      = mem_pkg::ADDR_W,
   parameter int BLOCK_W     = mem_pkg::BLOCK_W,
   parameter int MEM_LATENCY = 4
) (
   input  logic               clk,
   input  logic               reset,

   input  logic               req0,
   input  logic               rw0,
   input  logic [ADDR_W-1:0]  addr0,
   input  logic [BLOCK_W-1:0] wdata0,
   output logic               ack0,
   output logic [BLOCK_W-1:0] rdata0,

   input  logic               req1,
   input  logic               rw1,
   input  logic [ADDR_W-1:0]  addr1,
   input  logic [BLOCK_W-1:0] wdata1,
   output logic               ack1,
   output logic [BLOCK_W-1:0] rdata1,

   output logic               mem_rw,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [BLOCK_W-1:0] mem_wdata,
   input  logic [BLOCK_W-1:0] mem_rdata,

   output logic               busy
);
   import mem_pkg::*;

   // Window countdown starts at MEM_LATENCY-1 so ACCESS lasts exactly MEM_LATENCY cycles.
   localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

   arb_state_t state;
   logic [3:0] cnt;
   logic       lastGrant;
   logic       owner;
   logic       anyReq;
   logic       winner;
   logic       accessEnd;

   assign anyReq    = req0 | req1;
   assign winner    = pickWinner(req0, req1, lastGrant);
   assign accessEnd = (state == ACCESS) && (cnt == 4'd0);

   // Sequencer: state, access-window countdown, round-robin history and busy flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         lastGrant <= 1'b1;
         owner     <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (anyReq) begin
                  state     <= ACCESS;
                  cnt       <= CNT_LOAD;
                  lastGrant <= winner;
                  owner     <= winner;
                  busy      <= 1'b1;
               end
            end
            ACCESS: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Memory port: latch the winner's transfer at grant, release the write strobe when the window closes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_rw    <= RW_READ;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (state == IDLE) begin
         if (anyReq) begin
            mem_rw    <= winner ? rw1    : rw0;
            mem_addr  <= winner ? addr1  : addr0;
            mem_wdata <= winner ? wdata1 : wdata0;
         end else begin
            mem_rw <= RW_READ;
         end
      end else if (accessEnd) begin
         mem_rw <= RW_READ;
      end
   end

   // Completion: capture the read block for its owner and pulse the owner's ack during DONE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack0   <= 1'b0;
         ack1   <= 1'b0;
         rdata0 <= '0;
         rdata1 <= '0;
      end else begin
         ack0 <= accessEnd & ~owner;
         ack1 <= accessEnd & owner;
         if (accessEnd && (mem_rw == RW_READ)) begin
            if (owner) begin
               rdata1 <= mem_rdata;
            end else begin
               rdata0 <= mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance A uses a 4-cycle window, instance B a
// 1-cycle window. Each has its own behavioural main memory. A transaction-level
// reference model predicts port activity, acks, read data and memory contents.
module tb_mem_port_arbiter;
   import mem_pkg::*;

   localparam int LAT0  = 4;
   localparam int LAT1  = 1;
   localparam int NRAND = 800;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   logic         req0 [2];
   logic         rw0 [2];
   logic [9:0]   addr0 [2];
   logic [127:0] wdata0 [2];
   logic         ack0 [2];
   logic [127:0] rdata0 [2];
   logic         req1 [2];
   logic         rw1 [2];
   logic [9:0]   addr1 [2];
   logic [127:0] wdata1 [2];
   logic         ack1 [2];
   logic [127:0] rdata1 [2];
   logic         memRw [2];
   logic [9:0]   memAddr [2];
   logic [127:0] memWdata [2];
   logic [127:0] memRdata [2];
   logic         busy [2];

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(10), .BLOCK_W(128), .MEM_LATENCY(LAT0)) dutA (
      .clk(clk), .reset(reset),
      .req0(req0[0]), .rw0(rw0[0]), .addr0(addr0[0]), .wdata0(wdata0[0]), .ack0(ack0[0]), .rdata0(rdata0[0]),
      .req1(req1[0]), .rw1(rw1[0]), .addr1(addr1[0]), .wdata1(wdata1[0]), .ack1(ack1[0]), .rdata1(rdata1[0]),
      .mem_rw(memRw[0]), .mem_addr(memAddr[0]), .mem_wdata(memWdata[0]), .mem_rdata(memRdata[0]),
      .busy(busy[0])
   );

   mem_port_arbiter #(.ADDR_W(10), .BLOCK_W(128), .MEM_LATENCY(LAT1)) dutB (
      .clk(clk), .reset(reset),
      .req0(req0[1]), .rw0(rw0[1]), .addr0(addr0[1]), .wdata0(wdata0[1]), .ack0(ack0[1]), .rdata0(rdata0[1]),
      .req1(req1[1]), .rw1(rw1[1]), .addr1(addr1[1]), .wdata1(wdata1[1]), .ack1(ack1[1]), .rdata1(rdata1[1]),
      .mem_rw(memRw[1]), .mem_addr(memAddr[1]), .mem_wdata(memWdata[1]), .mem_rdata(memRdata[1]),
      .busy(busy[1])
   );

   // Main memories: unwritten blocks read back a fixed address-derived pattern.
   logic [127:0] memArr [2][1024];
   bit           memWritten [2][1024];

   function automatic logic [127:0] initBlock(input logic [9:0] a);
      return {4{22'h2D5A5A, a}};
   endfunction

   assign memRdata[0] = memWritten[0][memAddr[0]] ? memArr[0][memAddr[0]] : initBlock(memAddr[0]);
   assign memRdata[1] = memWritten[1][memAddr[1]] ? memArr[1][memAddr[1]] : initBlock(memAddr[1]);

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (memRw[i] === 1'b1) begin
            memArr[i][memAddr[i]]     <= memWdata[i];
            memWritten[i][memAddr[i]] <= 1'b1;
         end
      end
   end

   // Reference model: one transaction at a time, phase counts cycles since grant.
   bit           mActive [2];
   int           mPhase [2];
   bit           mWho [2];
   logic         mRw [2];
   logic [9:0]   mAddr [2];
   logic [127:0] mWd [2];
   bit           mLast [2];
   logic [127:0] mRd [2][2];
   logic [127:0] refMem [2][1024];
   bit           refWritten [2][1024];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   function automatic int latOf(input int i);
      return (i == 0) ? LAT0 : LAT1;
   endfunction

   function automatic logic [127:0] refRead(input int i, input logic [9:0] a);
      return refWritten[i][a] ? refMem[i][a] : initBlock(a);
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk(input string tag, input int inst, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s[%0d] observed=%h expected=%h", tag, inst, obs, exp);
      end
   endtask

   // A write that already saw at least one ACCESS edge has reached memory.
   task automatic modelReset(input int i);
      if (mActive[i] && mRw[i] == RW_WRITE && mPhase[i] >= 2) begin
         refMem[i][mAddr[i]]     = mWd[i];
         refWritten[i][mAddr[i]] = 1'b1;
      end
      mActive[i] = 1'b0;
      mPhase[i]  = 0;
      mLast[i]   = 1'b1;
      mRw[i]     = RW_READ;
      mAddr[i]   = '0;
      mWd[i]     = '0;
      mRd[i][0]  = '0;
      mRd[i][1]  = '0;
   endtask

   task automatic modelEdge(input int i);
      int lat;
      lat = latOf(i);
      if (reset) begin
         modelReset(i);
      end else if (mActive[i]) begin
         if (mPhase[i] == lat + 1) begin
            mActive[i] = 1'b0;
         end else begin
            mPhase[i]++;
            if (mPhase[i] == lat + 1) begin
               if (mRw[i] == RW_WRITE) begin
                  refMem[i][mAddr[i]]     = mWd[i];
                  refWritten[i][mAddr[i]] = 1'b1;
               end else begin
                  mRd[i][mWho[i]] = refRead(i, mAddr[i]);
               end
            end
         end
      end else if (req0[i] === 1'b1 || req1[i] === 1'b1) begin
         if (req0[i] === 1'b1 && req1[i] === 1'b1) mWho[i] = ~mLast[i];
         else mWho[i] = (req1[i] === 1'b1);
         mLast[i]   = mWho[i];
         mRw[i]     = mWho[i] ? rw1[i] : rw0[i];
         mAddr[i]   = mWho[i] ? addr1[i] : addr0[i];
         mWd[i]     = mWho[i] ? wdata1[i] : wdata0[i];
         mActive[i] = 1'b1;
         mPhase[i]  = 1;
      end
   endtask

   task automatic checkAll();
      for (int i = 0; i < 2; i++) begin
         int lat;
         bit inWin;
         bit inDone;
         lat    = latOf(i);
         inWin  = mActive[i] && (mPhase[i] <= lat);
         inDone = mActive[i] && (mPhase[i] == lat + 1);
         chk("busy", i, busy[i], mActive[i]);
         chk("mem_rw", i, memRw[i], inWin ? mRw[i] : RW_READ);
         chk("ack0", i, ack0[i], inDone && !mWho[i]);
         chk("ack1", i, ack1[i], inDone && mWho[i]);
         chk("rdata0", i, rdata0[i], mRd[i][0]);
         chk("rdata1", i, rdata1[i], mRd[i][1]);
         if (inWin) begin
            chk("mem_addr", i, memAddr[i], mAddr[i]);
            chk("mem_wdata", i, memWdata[i], mWd[i]);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) modelEdge(i);
      #1;
      checkAll();
   endtask

   task automatic setReq(input int i, input bit side, input logic r, input logic rw, input logic [9:0] a, input logic [127:0] d);
      if (side) begin
         req1[i] = r; rw1[i] = rw; addr1[i] = a; wdata1[i] = d;
      end else begin
         req0[i] = r; rw0[i] = rw; addr0[i] = a; wdata0[i] = d;
      end
   endtask

   function automatic bit ackOf(input int i, input bit side);
      return side ? (ack1[i] === 1'b1) : (ack0[i] === 1'b1);
   endfunction

   function automatic bit reqOf(input int i, input bit side);
      return side ? (req1[i] === 1'b1) : (req0[i] === 1'b1);
   endfunction

   // One transfer from an idle arbiter; returns cycles from grant edge to ack and write-strobe cycles.
   task automatic xfer(input int i, input bit side, input logic rw, input logic [9:0] a, input logic [127:0] d,
                       output int steps, output int rwCycles);
      bit got;
      got = 1'b0; steps = 0; rwCycles = 0;
      setReq(i, side, 1'b1, rw, a, d);
      while (!got && steps < 40) begin
         step();
         steps++;
         if (memRw[i] === 1'b1) rwCycles++;
         if (ackOf(i, side)) got = 1'b1;
      end
      setReq(i, side, 1'b0, rw, a, d);
      total++;
      assert (got)
      else begin
         bad++;
         $error("FAIL xfer_timeout[%0d] observed=no ack expected=ack within 40 cycles", i);
      end
      step();
   endtask

   task automatic randDrive(input int i, input bit side);
      int sel;
      if (!reqOf(i, side)) begin
         if ($urandom_range(0, 2) == 0)
            setReq(i, side, 1'b1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 31)), rand128());
      end else if (ackOf(i, side)) begin
         setReq(i, side, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 31)), rand128());
      end else begin
         sel = $urandom_range(0, 59);
         if (sel == 0)
            setReq(i, side, 1'b0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 31)), rand128());
         else if (sel < 8)
            setReq(i, side, 1'b1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 31)), rand128());
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int steps;
      int rwc;
      int guard;
      int mis;
      int orderQ[$];
      int cycQ[$];
      int expOrder[4];
      logic [9:0] nextAddr;
      logic nextRw;

      expOrder = '{0, 1, 0, 1};
      for (int i = 0; i < 2; i++) begin
         setReq(i, 1'b0, 1'b0, RW_READ, '0, '0);
         setReq(i, 1'b1, 1'b0, RW_READ, '0, '0);
      end

      // Reset state
      reset = 1'b1;
      repeat (3) step();
      for (int i = 0; i < 2; i++) begin
         chk("rst_mem_addr", i, memAddr[i], 10'h000);
         chk("rst_mem_wdata", i, memWdata[i], 128'h0);
      end
      reset = 1'b0;
      step();

      // Read of block 0x000 by requester 0
      xfer(0, 1'b0, RW_READ, 10'h000, '0, steps, rwc);
      chk("t1_latency", 0, steps, LAT0 + 1);
      chk("t1_rw_cycles", 0, rwc, 0);
      chk("t1_rdata0", 0, rdata0[0], initBlock(10'h000));

      // Write of block 0x200 by requester 1
      xfer(0, 1'b1, RW_WRITE, 10'h200, 128'hFF, steps, rwc);
      chk("t2_latency", 0, steps, LAT0 + 1);
      chk("t2_rw_cycles", 0, rwc, LAT0);
      chk("t2_mem_block", 0, memArr[0][10'h200], 128'hFF);
      chk("t2_rdata1_kept", 0, rdata1[0], 128'h0);

      // Write-through visibility across requesters
      xfer(0, 1'b0, RW_WRITE, 10'h000, 128'hFF, steps, rwc);
      xfer(0, 1'b1, RW_READ, 10'h000, '0, steps, rwc);
      chk("t3_rdata1_low", 0, rdata1[0][7:0], 8'hFF);

      // Contention right after reset, both requests held high
      reset = 1'b1;
      step();
      reset = 1'b0;
      setReq(0, 1'b0, 1'b1, RW_READ, 10'h005, '0);
      setReq(0, 1'b1, 1'b1, RW_WRITE, 10'h006, rand128());
      guard = 0;
      while (orderQ.size() < 4 && guard < 100) begin
         step();
         guard++;
         if (ack0[0] === 1'b1) begin orderQ.push_back(0); cycQ.push_back(cyc); end
         if (ack1[0] === 1'b1) begin orderQ.push_back(1); cycQ.push_back(cyc); end
      end
      total++;
      assert (orderQ.size() >= 4)
      else begin
         bad++;
         $error("FAIL t4_ack_count observed=%0d expected=4", orderQ.size());
      end
      if (orderQ.size() >= 4) begin
         for (int k = 0; k < 4; k++) chk("t4_grant_order", k, orderQ[k], expOrder[k]);
         chk("t4_regrant_gap", 0, cycQ[1] - cycQ[0], LAT0 + 2);
      end
      setReq(0, 1'b0, 1'b0, RW_READ, '0, '0);
      setReq(0, 1'b1, 1'b0, RW_READ, '0, '0);
      step();

      // Reset in the second ACCESS cycle of a write
      setReq(0, 1'b0, 1'b1, RW_WRITE, 10'h033, 128'hA5A5_0000_1234_5678_9ABC_DEF0_0F0F_F0F0);
      step();
      step();
      #2;
      reset = 1'b1;
      #1;
      chk("t5_async_mem_rw", 0, memRw[0], 1'b0);
      chk("t5_async_busy", 0, busy[0], 1'b0);
      chk("t5_async_ack0", 0, ack0[0], 1'b0);
      for (int i = 0; i < 2; i++) modelReset(i);
      checkAll();
      setReq(0, 1'b0, 1'b0, RW_READ, '0, '0);
      step();
      reset = 1'b0;
      xfer(0, 1'b1, RW_READ, 10'h033, '0, steps, rwc);
      chk("t5_after_latency", 0, steps, LAT0 + 1);
      chk("t5_after_rdata1", 0, rdata1[0], refRead(0, 10'h033));

      // One-cycle window, requester 0 held continuously with a new block each time
      cycQ.delete();
      nextAddr = 10'h100;
      nextRw   = RW_WRITE;
      setReq(1, 1'b0, 1'b1, nextRw, nextAddr, rand128());
      for (int n = 0; n < 15; n++) begin
         step();
         if (ack0[1] === 1'b1) begin
            cycQ.push_back(cyc);
            nextAddr = nextAddr + 10'd1;
            nextRw   = ~nextRw;
            setReq(1, 1'b0, 1'b1, nextRw, nextAddr, rand128());
         end
      end
      setReq(1, 1'b0, 1'b0, RW_READ, '0, '0);
      step();
      chk("t6_ack_count", 1, cycQ.size() >= 4, 1'b1);
      for (int k = 1; k < cycQ.size(); k++) chk("t6_ack_period", k, cycQ[k] - cycQ[k-1], LAT1 + 2);

      // Randomised traffic on both instances
      for (int n = 0; n < NRAND; n++) begin
         for (int i = 0; i < 2; i++) begin
            randDrive(i, 1'b0);
            randDrive(i, 1'b1);
         end
         step();
      end
      for (int i = 0; i < 2; i++) begin
         setReq(i, 1'b0, 1'b0, RW_READ, '0, '0);
         setReq(i, 1'b1, 1'b0, RW_READ, '0, '0);
      end
      repeat (12) step();

      for (int i = 0; i < 2; i++) begin
         mis = 0;
         for (int a = 0; a < 1024; a++) begin
            if (memWritten[i][a] != refWritten[i][a]) mis++;
            else if (refWritten[i][a] && (memArr[i][a] !== refMem[i][a])) mis++;
         end
         chk("mem_image", i, mis, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
